sha256_msg_padder: RTL and testbench

Upstream front end for the single-tile SHA-256 core. Accepts an arbitrary-length byte stream with valid/ready handshake, packs each message (1..MAX_LEN bytes) big-endian into a 512-bit block, and applies FIPS 180-4 padding: 0x80 terminator, zero fill, 64-bit bit length. The resulting block feeds the core's 512-bit `d_i` input. Messages longer than one block are rejected with an error pulse and produce no block.

---
 rtl/sha256_msg_padder.sv | 130 +++++++++++++
 tb/tb_sha256_msg_padder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - packs a byte-stream message into one FIPS 180-4 padded 512-bit block
module sha256_msg_padder #(
    parameter int MAX_LEN = 55
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   byte_i,
    input  logic         byte_valid_i,
    input  logic         byte_last_i,
    output logic         byte_ready_o,
    output logic [511:0] block_o,
    output logic         block_valid_o,
    input  logic         block_ready_i,
    output logic         err_o
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        PAD   = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   cnt_q;
    logic [5:0]   len_q;
    logic [7:0]   buf_q [MAX_LEN];
    logic [511:0] padded;

    logic hs, store, inc_cnt, clr_cnt, set_len, load_block, err_d;

    always_comb begin
        state_d       = state_q;
        byte_ready_o  = (state_q == ACCUM) || (state_q == DRAIN);
        block_valid_o = (state_q == VALID);
        hs            = byte_valid_i && byte_ready_o;
        store         = 1'b0;
        inc_cnt       = 1'b0;
        clr_cnt       = 1'b0;
        set_len       = 1'b0;
        load_block    = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            ACCUM: begin
                if (hs) begin
                    if (cnt_q < 6'(MAX_LEN)) begin
                        store   = 1'b1;
                        inc_cnt = 1'b1;
                        if (byte_last_i) begin
                            set_len = 1'b1;
                            state_d = PAD;
                        end
                    end else if (byte_last_i) begin
                        err_d   = 1'b1;
                        clr_cnt = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs && byte_last_i) begin
                    err_d   = 1'b1;
                    clr_cnt = 1'b1;
                    state_d = ACCUM;
                end
            end
            PAD: begin
                load_block = 1'b1;
                state_d    = VALID;
            end
            VALID: begin
                if (block_ready_i) begin
                    clr_cnt = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Slots past len are masked here so stale bytes from longer earlier messages never leak.
    always_comb begin
        padded = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (6'(i) < len_q) begin
                padded[511-8*i -: 8] = buf_q[i];
            end else if (6'(i) == len_q) begin
                padded[511-8*i -: 8] = 8'h80;
            end
        end
        if (len_q == 6'(MAX_LEN)) begin
            padded[511-8*MAX_LEN -: 8] = 8'h80;
        end
        padded[63:0] = {55'b0, len_q, 3'b000};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            len_q   <= '0;
            block_o <= '0;
            err_o   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            err_o   <= err_d;
            if (clr_cnt) begin
                cnt_q <= '0;
            end else if (inc_cnt) begin
                cnt_q <= cnt_q + 6'd1;
            end
            if (set_len) begin
                len_q <= cnt_q + 6'd1;
            end
            if (load_block) begin
                block_o <= padded;
            end
            for (int i = 0; i < MAX_LEN; i++) begin
                if (store && cnt_q == 6'(i)) begin
                    buf_q[i] <= byte_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - scoreboard bench for sha256_msg_padder
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   byte_i;
    logic         byte_valid_i;
    logic         byte_last_i;
    logic         byte_ready_o;
    logic [511:0] block_o;
    logic         block_valid_o;
    logic         block_ready_i;
    logic         err_o;

    int errors  = 0;
    int checks  = 0;
    int exp_err = 0;
    int obs_err = 0;
    logic [511:0] exp_q [$];

    sha256_msg_padder #(.MAX_LEN(55)) dut (
        .clk           (clk),
        .reset         (reset),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_last_i   (byte_last_i),
        .byte_ready_o  (byte_ready_o),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pad_model(input logic [7:0] m [$]);
        logic [511:0] b = '0;
        int n = m.size();
        for (int i = 0; i < n; i++) b[511-8*i -: 8] = m[i];
        b[511-8*n -: 8] = 8'h80;
        b[63:0] = 64'(n * 8);
        return b;
    endfunction

    // Scoreboard: every accepted block is popped and compared; err pulses counted.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (err_o) obs_err++;
            if (block_valid_o && block_ready_i) begin
                chk("sb_block_expected", 512'(exp_q.size() != 0), 512'd1);
                if (exp_q.size() != 0) chk("sb_block", block_o, exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_i       = b;
        byte_last_i  = last;
        while (!byte_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("byte_ready_timeout", 512'd0, 512'd1);
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m [$], input bit gaps);
        if (m.size() <= 55) exp_q.push_back(pad_model(m));
        else exp_err++;
        for (int i = 0; i < m.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(m[i], i == m.size() - 1);
        end
    endtask

    logic [7:0]   msg [$];
    logic [511:0] held;

    initial begin
        reset = 1'b0;
        byte_i = '0;
        byte_valid_i = 1'b0;
        byte_last_i = 1'b0;
        block_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_block", block_o, 512'd0);
        chk("rst_valid", 512'(block_valid_o), 512'd0);
        chk("rst_err", 512'(err_o), 512'd0);
        chk("rst_ready", 512'(byte_ready_o), 512'd1);
        reset = 1'b1;

        // "A": fixed expected block and n+2 / n+3 timing
        msg = '{8'h41};
        send_msg(msg, 1'b0);
        @(negedge clk);
        chk("a_pad_valid", 512'(block_valid_o), 512'd0);
        chk("a_pad_ready", 512'(byte_ready_o), 512'd0);
        @(negedge clk);
        chk("a_valid", 512'(block_valid_o), 512'd1);
        chk("a_block", block_o, {16'h4180, 432'd0, 64'h8});
        @(negedge clk);
        chk("a_valid_pulse", 512'(block_valid_o), 512'd0);
        chk("a_ready_back", 512'(byte_ready_o), 512'd1);

        // "abc" then "Z" back to back
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(msg, 1'b0);
        msg = '{8'h5A};
        send_msg(msg, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("z_block", block_o, {16'h5A80, 432'd0, 64'h8});

        // 55-byte boundary
        msg = {};
        for (int i = 0; i < 55; i++) msg.push_back(8'(i));
        send_msg(msg, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("max_term", 512'(block_o[71:64]), 512'h80);
        chk("max_len", 512'(block_o[63:0]), 512'h1B8);

        // 56 bytes: rejected
        msg = {};
        for (int i = 0; i < 56; i++) msg.push_back(8'(i + 100));
        send_msg(msg, 1'b0);
        @(negedge clk);
        chk("e56_err", 512'(err_o), 512'd1);
        chk("e56_novalid", 512'(block_valid_o), 512'd0);
        @(negedge clk);
        chk("e56_err_pulse", 512'(err_o), 512'd0);
        msg = '{8'h42};
        send_msg(msg, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("b_block", block_o, {16'h4280, 432'd0, 64'h8});

        // Backpressure in VALID
        @(posedge clk);
        #1;
        block_ready_i = 1'b0;
        msg = '{8'h78, 8'h79};
        send_msg(msg, 1'b0);
        @(negedge clk);
        @(negedge clk);
        held = block_o;
        chk("bp_block", held, {24'h787980, 424'd0, 64'h10});
        byte_valid_i = 1'b1;
        byte_i = 8'hEE;
        byte_last_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_held", 512'(block_valid_o), 512'd1);
            chk("bp_ready_low", 512'(byte_ready_o), 512'd0);
            chk("bp_block_stable", block_o, held);
        end
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        byte_last_i = 1'b0;
        block_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_released", 512'(block_valid_o), 512'd0);
        msg = '{8'h51};
        send_msg(msg, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_block", block_o, {16'h5180, 432'd0, 64'h8});

        // Async reset mid-message
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_block", block_o, 512'd0);
        chk("mrst_valid", 512'(block_valid_o), 512'd0);
        chk("mrst_ready", 512'(byte_ready_o), 512'd1);
        chk("mrst_err", 512'(err_o), 512'd0);
        @(negedge clk);
        reset = 1'b1;
        msg = '{8'h43};
        send_msg(msg, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("c_block", block_o, {16'h4380, 432'd0, 64'h8});

        // 60 bytes with gaps: drained, one error
        msg = {};
        for (int i = 0; i < 60; i++) msg.push_back(8'($urandom_range(0, 255)));
        send_msg(msg, 1'b1);
        @(negedge clk);
        chk("e60_err", 512'(err_o), 512'd1);
        @(negedge clk);
        chk("e60_err_pulse", 512'(err_o), 512'd0);
        msg = '{8'h01, 8'h02};
        send_msg(msg, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("e60_next_block", block_o, {24'h010280, 424'd0, 64'h10});

        repeat (5) @(negedge clk);
        chk("sb_drained", 512'(exp_q.size()), 512'd0);
        chk("err_count", 512'(obs_err), 512'(exp_err));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
